// File: rtl/floo_shared_credit_counter.sv
// ----------------------------------------------------------------------------
// floo_shared_credit_counter
//
// Credit tracker for one router output port. The downstream input buffer has
// private slots for each VC plus a pool of shared slots that any VC may use.
// The counter tracks:
//   - free private credits per VC,
//   - free shared credits,
//   - shared slots currently borrowed by each VC.
// Borrow tracking makes sure that a returned credit goes back to the pool it
// was taken from.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   credit_valid_i/id_i      one credit returned from downstream (refill)
//   consume_credit_valid_i/  one flit sent downstream (consume)
//     consume_credit_id_i
//   err_clr_i                clears the sticky error flags
//   vc_not_full_o            VC may send one flit (private or shared credit)
//   vc_priv_cnt_o            free private credits per VC
//   shared_cnt_o             free shared credits
//   underflow_o              sticky: consume with no credit available
//   overflow_o               sticky: refill with nothing outstanding
//
// All outputs are derived only from registered state, so there is no
// combinational path from any input to any output.
// ----------------------------------------------------------------------------
module floo_shared_credit_counter #(
    parameter int unsigned NumVC         = 5,
    parameter int unsigned VCIdxWidth    = (NumVC > 1) ? $clog2(NumVC) : 1,
    parameter int unsigned VCDepth       = 2,
    parameter int unsigned DeeperVCId    = 0,
    parameter int unsigned DeeperVCDepth = 2,
    parameter int unsigned SharedDepth   = 4,
    parameter int unsigned CntWidth      =
        $clog2(((VCDepth > DeeperVCDepth) ? VCDepth : DeeperVCDepth) + 1),
    // Kept at least 1 bit wide so the ports stay legal when there is no pool.
    parameter int unsigned ShWidth       =
        (SharedDepth > 0) ? $clog2(SharedDepth + 1) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               credit_valid_i,
    input  logic [VCIdxWidth-1:0]              credit_id_i,
    input  logic                               consume_credit_valid_i,
    input  logic [VCIdxWidth-1:0]              consume_credit_id_i,
    input  logic                               err_clr_i,
    output logic [NumVC-1:0]                   vc_not_full_o,
    output logic [NumVC-1:0][CntWidth-1:0]     vc_priv_cnt_o,
    output logic [ShWidth-1:0]                 shared_cnt_o,
    output logic                               underflow_o,
    output logic                               overflow_o
);

    // Private depth of VC v.
    function automatic logic [CntWidth-1:0] vc_depth(input int unsigned v);
        return (v == DeeperVCId) ? CntWidth'(DeeperVCDepth) : CntWidth'(VCDepth);
    endfunction

    logic [NumVC-1:0][CntWidth-1:0] priv_q, priv_d;
    logic [NumVC-1:0][ShWidth-1:0]  borrow_q, borrow_d;
    logic [ShWidth-1:0]             shared_q, shared_d;
    logic                           underflow_q, underflow_d;
    logic                           overflow_q, overflow_d;
    logic                           ovf_set, unf_set;

    // ------------------------------------------------------------------------
    // Next-state logic. The refill is applied first. The consume then works
    // on the refill-updated values. As a result, a credit that comes back
    // through the shared pool in the same cycle can be reused right away.
    // A same-VC refill and consume in one cycle nets to no change.
    // ------------------------------------------------------------------------
    always_comb begin
        priv_d   = priv_q;
        borrow_d = borrow_q;
        shared_d = shared_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;

        // Refill
        if (credit_valid_i) begin
            // Out-of-range ids match no VC below and only raise the flag.
            if (32'(credit_id_i) >= NumVC) ovf_set = 1'b1;
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (credit_id_i == VCIdxWidth'(v)) begin
                    // Borrowed slots are returned before private ones. Any
                    // outstanding borrow means the shared pool is owed.
                    if (SharedDepth > 0 && borrow_d[v] != '0) begin
                        borrow_d[v] = borrow_d[v] - ShWidth'(1);
                        shared_d    = shared_d + ShWidth'(1);
                    end else if (priv_d[v] < vc_depth(v)) begin
                        priv_d[v] = priv_d[v] + CntWidth'(1);
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
        end

        // Consume
        if (consume_credit_valid_i) begin
            if (32'(consume_credit_id_i) >= NumVC) unf_set = 1'b1;
            for (int unsigned v = 0; v < NumVC; v++) begin
                if (consume_credit_id_i == VCIdxWidth'(v)) begin
                    // Private credits are spent first so the shared pool is
                    // kept for VCs that have run dry.
                    if (priv_d[v] != '0) begin
                        priv_d[v] = priv_d[v] - CntWidth'(1);
                    end else if (SharedDepth > 0 && shared_d != '0) begin
                        shared_d    = shared_d - ShWidth'(1);
                        borrow_d[v] = borrow_d[v] + ShWidth'(1);
                    end else begin
                        unf_set = 1'b1;
                    end
                end
            end
        end

        // An error raised in the same cycle as a clear takes priority.
        underflow_d = unf_set | (underflow_q & ~err_clr_i);
        overflow_d  = ovf_set | (overflow_q  & ~err_clr_i);
    end

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned v = 0; v < NumVC; v++) priv_q[v] <= vc_depth(v);
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            priv_q      <= priv_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    if (SharedDepth > 0) begin : g_shared
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shared_q <= ShWidth'(SharedDepth);
                borrow_q <= '0;
            end else begin
                shared_q <= shared_d;
                borrow_q <= borrow_d;
            end
        end
    end else begin : g_no_shared
        // Without a pool, the design is a plain per-VC private counter.
        assign shared_q = '0;
        assign borrow_q = '0;
    end

    // ------------------------------------------------------------------------
    // Outputs, taken from registered state only.
    // ------------------------------------------------------------------------
    always_comb begin
        vc_not_full_o = '0;
        for (int unsigned v = 0; v < NumVC; v++)
            vc_not_full_o[v] = (priv_q[v] != '0) | (shared_q != '0);
    end

    assign vc_priv_cnt_o = priv_q;
    assign shared_cnt_o  = shared_q;
    assign underflow_o   = underflow_q;
    assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_floo_shared_credit_counter.sv
// Directed checks followed by a legal-traffic run against a reference model,
// using the default configuration: 5 VCs, private depth 2, shared depth 4.
module tb_floo_shared_credit_counter;

    localparam int NV = 5;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           credit_valid_i = 1'b0;
    logic [2:0]     credit_id_i = '0;
    logic           consume_credit_valid_i = 1'b0;
    logic [2:0]     consume_credit_id_i = '0;
    logic           err_clr_i = 1'b0;
    logic [4:0]     vc_not_full_o;
    logic [4:0][1:0] vc_priv_cnt_o;
    logic [2:0]     shared_cnt_o;
    logic           underflow_o;
    logic           overflow_o;

    int nchk = 0;
    int nerr = 0;

    floo_shared_credit_counter dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .credit_valid_i         (credit_valid_i),
        .credit_id_i            (credit_id_i),
        .consume_credit_valid_i (consume_credit_valid_i),
        .consume_credit_id_i    (consume_credit_id_i),
        .err_clr_i              (err_clr_i),
        .vc_not_full_o          (vc_not_full_o),
        .vc_priv_cnt_o          (vc_priv_cnt_o),
        .shared_cnt_o           (shared_cnt_o),
        .underflow_o            (underflow_o),
        .overflow_o             (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Packs the per-VC private counts the same way vc_priv_cnt_o does.
    function automatic int pk(input int p0, input int p1, input int p2, input int p3, input int p4);
        return (p4 << 8) | (p3 << 6) | (p2 << 4) | (p1 << 2) | p0;
    endfunction

    // One clock: drive the inputs, pass the edge, then sample 1 time unit after it.
    task automatic step(input logic cv, input int cid, input logic kv, input int kid, input logic clr);
        credit_valid_i         = cv;
        credit_id_i            = 3'(cid);
        consume_credit_valid_i = kv;
        consume_credit_id_i    = 3'(kid);
        err_clr_i              = clr;
        @(posedge clk_i);
        #1;
        credit_valid_i         = 1'b0;
        consume_credit_valid_i = 1'b0;
        err_clr_i              = 1'b0;
    endtask

    task automatic consume(input int v);
        step(1'b0, 0, 1'b1, v, 1'b0);
    endtask

    task automatic refill(input int v);
        step(1'b1, v, 1'b0, 0, 1'b0);
    endtask

    // Reference model
    int m_priv[NV];
    int m_bor[NV];
    int m_sh;

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_priv[v] = 2;
            m_bor[v]  = 0;
        end
        m_sh = 4;
    endtask

    function automatic int model_pk();
        return pk(m_priv[0], m_priv[1], m_priv[2], m_priv[3], m_priv[4]);
    endfunction

    function automatic int model_nf();
        int r = 0;
        for (int v = 0; v < NV; v++)
            if (m_priv[v] > 0 || m_sh > 0) r |= (1 << v);
        return r;
    endfunction

    initial begin
        // ---------------- Reset ----------------
        #23;
        chk("rst_low_not_full", int'(vc_not_full_o), 5'b11111);
        rst_ni = 1'b1;
        #4;
        chk("rst_not_full", int'(vc_not_full_o), 5'b11111);
        chk("rst_priv", int'(vc_priv_cnt_o), pk(2, 2, 2, 2, 2));
        chk("rst_shared", int'(shared_cnt_o), 4);
        chk("rst_unf", int'(underflow_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);

        // ------- VC1 three consumes: third one borrows a shared slot -------
        consume(1);
        chk("c1_priv_after1", int'(vc_priv_cnt_o), pk(2, 1, 2, 2, 2));
        consume(1);
        consume(1);
        chk("c1_priv", int'(vc_priv_cnt_o), pk(2, 0, 2, 2, 2));
        chk("c1_shared", int'(shared_cnt_o), 3);
        chk("c1_not_full", int'(vc_not_full_o), 5'b11111);

        // ---- Drain VC2: 2 private + 3 shared, then one more -> underflow ----
        for (int i = 0; i < 5; i++) consume(2);
        chk("drain_priv", int'(vc_priv_cnt_o), pk(2, 0, 0, 2, 2));
        chk("drain_shared", int'(shared_cnt_o), 0);
        chk("drain_not_full", int'(vc_not_full_o), 5'b11001);
        chk("drain_unf_none", int'(underflow_o), 0);
        consume(2);
        chk("unf_flag", int'(underflow_o), 1);
        chk("unf_priv", int'(vc_priv_cnt_o), pk(2, 0, 0, 2, 2));
        chk("unf_shared", int'(shared_cnt_o), 0);
        consume(4);                      // unrelated traffic: flag stays set
        chk("unf_sticky", int'(underflow_o), 1);
        step(1'b0, 0, 1'b0, 0, 1'b1);
        chk("unf_clr", int'(underflow_o), 0);
        refill(4);                       // give back the credit consumed above

        // ---- VC1 refills: first pays back shared, second refills private ----
        refill(1);
        chk("r1_shared", int'(shared_cnt_o), 1);
        chk("r1_priv", int'(vc_priv_cnt_o), pk(2, 0, 0, 2, 2));
        refill(1);
        chk("r2_shared", int'(shared_cnt_o), 1);
        chk("r2_priv", int'(vc_priv_cnt_o), pk(2, 1, 0, 2, 2));

        // ---- VC3 at priv=0, borrow=1, shared=0, then same-cycle refill+consume ----
        consume(3);
        consume(3);
        consume(3);
        chk("vc3_setup_priv", int'(vc_priv_cnt_o), pk(2, 1, 0, 0, 2));
        chk("vc3_setup_shared", int'(shared_cnt_o), 0);
        chk("vc3_setup_nf", int'(vc_not_full_o), 5'b10011);
        step(1'b1, 3, 1'b1, 3, 1'b0);
        chk("same_vc_priv", int'(vc_priv_cnt_o), pk(2, 1, 0, 0, 2));
        chk("same_vc_shared", int'(shared_cnt_o), 0);
        chk("same_vc_unf", int'(underflow_o), 0);
        chk("same_vc_ovf", int'(overflow_o), 0);

        // ---- Cross-VC: refill VC2 returns a shared slot that VC3 uses at once ----
        step(1'b1, 2, 1'b1, 3, 1'b0);
        chk("cross_shared", int'(shared_cnt_o), 0);
        chk("cross_unf", int'(underflow_o), 0);
        chk("cross_priv", int'(vc_priv_cnt_o), pk(2, 1, 0, 0, 2));
        // Different VCs, both from private: refill VC1 and consume VC4
        step(1'b1, 1, 1'b1, 4, 1'b0);
        chk("diff_priv", int'(vc_priv_cnt_o), pk(2, 2, 0, 0, 1));

        // ---- Overflow on a full VC0, clear, and set-wins-over-clear ----
        refill(0);
        chk("ovf_flag", int'(overflow_o), 1);
        chk("ovf_priv", int'(vc_priv_cnt_o), pk(2, 2, 0, 0, 1));
        step(1'b0, 0, 1'b0, 0, 1'b1);
        chk("ovf_clr", int'(overflow_o), 0);
        step(1'b1, 0, 1'b0, 0, 1'b1);
        chk("ovf_set_wins", int'(overflow_o), 1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // ---- Out-of-range ids: state untouched, flags raised ----
        consume(5);
        chk("oor_unf", int'(underflow_o), 1);
        chk("oor_unf_priv", int'(vc_priv_cnt_o), pk(2, 2, 0, 0, 1));
        refill(7);
        chk("oor_ovf", int'(overflow_o), 1);
        chk("oor_ovf_shared", int'(shared_cnt_o), 0);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // ---- Asynchronous reset mid-operation restores full counters ----
        #2 rst_ni = 1'b0;
        #1;
        chk("midrst_priv", int'(vc_priv_cnt_o), pk(2, 2, 2, 2, 2));
        chk("midrst_shared", int'(shared_cnt_o), 4);
        #5 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // ---- Legal random traffic against the reference model ----
        model_reset();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic cv, kv;
            int   cid, kid;
            cid = $urandom_range(0, NV - 1);
            kid = $urandom_range(0, NV - 1);
            // A refill is legal only when something is outstanding. A consume
            // is legal only when the VC reports not-full at the start of the cycle.
            cv = ($urandom_range(0, 1) == 1) && (m_bor[cid] > 0 || m_priv[cid] < 2);
            kv = ($urandom_range(0, 1) == 1) && ((model_nf() >> kid) & 1) == 1;
            if (cv) begin
                if (m_bor[cid] > 0) begin m_bor[cid]--; m_sh++; end
                else m_priv[cid]++;
            end
            if (kv) begin
                if (m_priv[kid] > 0) m_priv[kid]--;
                else begin m_sh--; m_bor[kid]++; end
            end
            step(cv, cid, kv, kid, 1'b0);
            chk("rnd_priv", int'(vc_priv_cnt_o), model_pk());
            chk("rnd_shared", int'(shared_cnt_o), m_sh);
            chk("rnd_not_full", int'(vc_not_full_o), model_nf());
            chk("rnd_errs", int'({underflow_o, overflow_o}), 0);
            if (nerr > 20) break;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
